// File: rtl/elevator_engine.sv
// Elevator request engine: decides whether to stop at the current level and
// produces the next request queue (removal of served level, then append of new presses).
module elevator_engine (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ipmod30,
  input  logic [1:0] pos_lvl,
  input  logic [2:0] tail,
  input  logic [7:0] queue,
  output logic       stop_at_pos_lvl,
  output logic [7:0] next_queue_sub,
  output logic [2:0] next_tail_sub
);

  logic             r_stop;
  logic [7:0]       r_queue;
  logic [2:0]       r_tail;

  logic [2:0]       w_tailEff;
  logic             w_stop;
  logic [2:0]       w_cnt;
  logic [3:0][1:0]  w_slots;
  logic [3:0]       w_present;

  // Survivors are compacted in order; w_present records which levels remain queued
  always_comb begin
    w_tailEff = (tail > 3'd4) ? 3'd4 : tail;
    w_stop    = ipmod30[pos_lvl];
    w_cnt     = 3'd0;
    w_slots   = '0;
    w_present = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < w_tailEff) begin
        if (queue[2*k +: 2] == pos_lvl) begin
          w_stop = 1'b1;
        end else begin
          w_slots[w_cnt[1:0]]          = queue[2*k +: 2];
          w_present[queue[2*k +: 2]]   = 1'b1;
          w_cnt                        = w_cnt + 3'd1;
        end
      end
    end
    for (int l = 0; l < 4; l++) begin
      if (ipmod30[l] && (2'(l) != pos_lvl) && !w_present[l] && (w_cnt < 3'd4)) begin
        w_slots[w_cnt[1:0]] = 2'(l);
        w_cnt               = w_cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stop  <= 1'b0;
      r_queue <= 8'h00;
      r_tail  <= 3'd0;
    end else begin
      r_stop  <= w_stop;
      r_queue <= w_slots;
      r_tail  <= w_cnt;
    end
  end

  assign stop_at_pos_lvl = r_stop;
  assign next_queue_sub  = r_queue;
  assign next_tail_sub   = r_tail;

endmodule

// File: tb/tb_elevator_engine.sv
// Bench for elevator_engine: list-based reference model checked every cycle,
// plus literal expectations for the documented example scenarios.
module tb_elevator_engine;

  logic       clk;
  logic       rst;
  logic [3:0] ipmod30;
  logic [1:0] pos_lvl;
  logic [2:0] tail;
  logic [7:0] queue;
  logic       stop_at_pos_lvl;
  logic [7:0] next_queue_sub;
  logic [2:0] next_tail_sub;

  int total = 0;
  int bad   = 0;

  logic       expValid = 1'b0;
  logic       expStop;
  logic [7:0] expQueue;
  logic [2:0] expTail;

  elevator_engine dut (
    .clk             (clk),
    .rst             (rst),
    .ipmod30         (ipmod30),
    .pos_lvl         (pos_lvl),
    .tail            (tail),
    .queue           (queue),
    .stop_at_pos_lvl (stop_at_pos_lvl),
    .next_queue_sub  (next_queue_sub),
    .next_tail_sub   (next_tail_sub)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void model(input logic r, input logic [3:0] ip, input logic [1:0] pos,
                                input logic [2:0] t, input logic [7:0] q,
                                output logic s, output logic [7:0] nq, output logic [2:0] nt);
    int lst[$];
    int n;
    bit found;
    s  = 1'b0;
    nq = 8'h00;
    nt = 3'd0;
    if (r) return;
    n = (t > 3'd4) ? 4 : int'(t);
    s = ip[pos];
    for (int k = 0; k < n; k++) begin
      if (int'(q[2*k +: 2]) == int'(pos)) s = 1'b1;
      else lst.push_back(int'(q[2*k +: 2]));
    end
    for (int l = 0; l < 4; l++) begin
      found = 1'b0;
      foreach (lst[j]) if (lst[j] == l) found = 1'b1;
      if (ip[l] && l != int'(pos) && !found && lst.size() < 4) lst.push_back(l);
    end
    foreach (lst[j]) nq[2*j +: 2] = 2'(lst[j]);
    nt = 3'(lst.size());
  endfunction

  // Reference result for the inputs sampled at this edge
  always @(posedge clk) begin
    model(rst, ipmod30, pos_lvl, tail, queue, expStop, expQueue, expTail);
    expValid = 1'b1;
  end

  always @(negedge clk) begin
    if (expValid) begin
      total++;
      if (stop_at_pos_lvl !== expStop || next_queue_sub !== expQueue || next_tail_sub !== expTail) begin
        bad++;
        $display("[TB] FAIL model t=%0t actual stop=%b q=%b tail=%0d required stop=%b q=%b tail=%0d",
                 $time, stop_at_pos_lvl, next_queue_sub, next_tail_sub, expStop, expQueue, expTail);
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic [3:0] ip, input logic [1:0] pos,
                               input logic [2:0] t, input logic [7:0] q);
    rst     = r;
    ipmod30 = ip;
    pos_lvl = pos;
    tail    = t;
    queue   = q;
  endtask

  task automatic checkOutput(input string name, input logic s, input logic [7:0] q, input logic [2:0] t);
    total++;
    if (stop_at_pos_lvl !== s || next_queue_sub !== q || next_tail_sub !== t) begin
      bad++;
      $display("[TB] FAIL %s actual stop=%b q=%b tail=%0d required stop=%b q=%b tail=%0d",
               name, stop_at_pos_lvl, next_queue_sub, next_tail_sub, s, q, t);
    end
  endtask

  initial begin
    applyStimulus(1'b1, 4'b1111, 2'd2, 3'd3, 8'b10110110);
    @(negedge clk);
    checkOutput("reset", 1'b0, 8'h00, 3'd0);

    applyStimulus(1'b0, 4'b0000, 2'd0, 3'd0, 8'h00);
    @(negedge clk);
    checkOutput("idle", 1'b0, 8'h00, 3'd0);

    applyStimulus(1'b0, 4'b0001, 2'd0, 3'd0, 8'h00);
    @(negedge clk);
    checkOutput("press_here", 1'b1, 8'h00, 3'd0);

    applyStimulus(1'b0, 4'b1010, 2'd0, 3'd0, 8'h00);
    @(negedge clk);
    checkOutput("append_bd", 1'b0, 8'b00001101, 3'd2);

    applyStimulus(1'b0, 4'b0000, 2'd2, 3'd2, 8'b00000110);
    @(negedge clk);
    checkOutput("remove_c", 1'b1, 8'b00000001, 3'd1);

    applyStimulus(1'b0, 4'b0101, 2'd0, 3'd3, 8'b00111001);
    @(negedge clk);
    checkOutput("no_dup", 1'b1, 8'b00111001, 3'd3);

    applyStimulus(1'b0, 4'b1111, 2'd0, 3'd4, 8'b01111001);
    @(negedge clk);
    checkOutput("full_drop", 1'b1, 8'b01111001, 3'd4);

    applyStimulus(1'b0, 4'b0000, 2'd2, 3'd7, 8'b01111001);
    @(negedge clk);
    checkOutput("tail_clamp", 1'b1, 8'b00011101, 3'd3);

    applyStimulus(1'b0, 4'b0000, 2'd3, 3'd1, 8'b11111110);
    @(negedge clk);
    checkOutput("ignore_stale", 1'b0, 8'b00000010, 3'd1);

    applyStimulus(1'b1, 4'b1111, 2'd1, 3'd4, 8'hFF);
    @(negedge clk);
    checkOutput("mid_reset", 1'b0, 8'h00, 3'd0);

    for (int i = 0; i < 2000; i++) begin
      applyStimulus(($urandom_range(0, 19) == 0), 4'($urandom), 2'($urandom),
                    3'($urandom_range(0, 7)), 8'($urandom));
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
